// File: rtl/ins_fetch_unit.sv
// ----------------------------------------------------------------------------
// ins_fetch_unit
//
// Instruction fetch unit for the bythoven core. Reads one byte per cycle from
// a byte-wide memory with a combinational read port, assembles INS_BYTES of
// them into an instruction, and hands it to decode over valid/ready together
// with its PC and a pre-decoded "single note" flag. The unit owns the PC: it
// advances sequentially after every accepted instruction and can be
// redirected to any target at any time.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   When defined, a fetch that starts at a PC that is not a multiple of
//   INS_BYTES enters a sticky FAULT state (o_fault=1) instead of reading
//   memory; only a redirect or reset leaves it. When undefined, o_fault is
//   tied low and misaligned PCs simply fetch bytes pc..pc+INS_BYTES-1.
//
// Ports:
//   i_clkOut          clock, all state updates on the rising edge
//   i_reset           synchronous active-high reset
//   i_redirect        load i_redirect_pc and restart the fetch
//   i_redirect_pc     redirect target PC
//   o_raddr           memory byte address (combinational from pc and idx)
//   i_rdata           memory byte for o_raddr, same cycle
//   o_ins_valid       o_ins, o_ins_pc and o_is_single_note are valid
//   i_ins_ready       decode accepts the presented instruction
//   o_ins             assembled instruction
//   o_ins_pc          PC of o_ins
//   o_is_single_note  note field of o_ins is all zeros
//   o_fault           misaligned-PC fault (sticky)
// ----------------------------------------------------------------------------
module ins_fetch_unit #(
    parameter int                PC_W       = 64,
    parameter int                ADDR_W     = 10,
    parameter int                INS_BYTES  = 4,
    parameter int                BIG_ENDIAN = 0,
    parameter logic [PC_W-1:0]   RESET_PC   = '0,
    parameter int                NOTE_LSB   = 23,
    parameter int                NOTE_W     = 8
) (
    input  logic                   i_clkOut,
    input  logic                   i_reset,
    input  logic                   i_redirect,
    input  logic [PC_W-1:0]        i_redirect_pc,
    output logic [ADDR_W-1:0]      o_raddr,
    input  logic [7:0]             i_rdata,
    output logic                   o_ins_valid,
    input  logic                   i_ins_ready,
    output logic [8*INS_BYTES-1:0] o_ins,
    output logic [PC_W-1:0]        o_ins_pc,
    output logic                   o_is_single_note,
    output logic                   o_fault
);

    localparam int               IDX_W    = (INS_BYTES > 1) ? $clog2(INS_BYTES) : 1;
    localparam int               INS_W    = 8 * INS_BYTES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INS_BYTES - 1);
    localparam logic [PC_W-1:0]  PC_STEP  = PC_W'(INS_BYTES);
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [PC_W-1:0]  ALIGN_MASK = PC_W'(INS_BYTES - 1);
`endif

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        FAULT = 2'd2
`endif
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [IDX_W-1:0]   r_idx;
    logic [INS_W-1:0]   r_asm;
    logic [INS_W-1:0]   r_ins;
    logic [PC_W-1:0]    r_insPc;
    logic               r_insValid;
    logic               r_singleNote;
`ifdef FETCH_ALIGN_CHECK_EN
    logic               r_fault;
    logic               w_misaligned;
`endif

    logic [IDX_W-1:0]   w_lane;
    logic [INS_W-1:0]   w_asmNext;
    logic [ADDR_W-1:0]  w_raddr;

    // Memory address: walks pc, pc+1, ... while fetching and parks on pc
    // otherwise. Truncation to ADDR_W bits gives the wrap from top to 0.
    always_comb begin
        w_raddr = r_pc[ADDR_W-1:0];
        if (r_state == FETCH) begin
            w_raddr = r_pc[ADDR_W-1:0] + ADDR_W'(r_idx);
        end
    end

    // Byte lane the current memory byte belongs to, and the assembly buffer
    // with that lane replaced. On the last byte w_asmNext is the complete
    // instruction, so it can be registered straight into the output.
    always_comb begin
        w_lane = r_idx;
        if (BIG_ENDIAN != 0) begin
            w_lane = LAST_IDX - r_idx;
        end
        w_asmNext = r_asm;
        for (int k = 0; k < INS_BYTES; k++) begin
            if (w_lane == IDX_W'(k)) begin
                w_asmNext[8*k +: 8] = i_rdata;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misaligned = |(r_pc & ALIGN_MASK);
`endif

    // Fetch state machine. Reset beats redirect, redirect beats everything
    // else; a redirect arriving with an accepted instruction still lets that
    // transfer complete (valid drops) but the PC comes from the redirect.
    always_ff @(posedge i_clkOut) begin
        if (i_reset) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_idx        <= '0;
            r_asm        <= '0;
            r_ins        <= '0;
            r_insPc      <= '0;
            r_insValid   <= 1'b0;
            r_singleNote <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fault      <= 1'b0;
`endif
        end else if (i_redirect) begin
            r_pc       <= i_redirect_pc;
            r_idx      <= '0;
            r_asm      <= '0;
            r_insValid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (|(i_redirect_pc & ALIGN_MASK)) begin
                r_state <= FAULT;
                r_fault <= 1'b1;
            end else begin
                r_state <= FETCH;
                r_fault <= 1'b0;
            end
`else
            r_state    <= FETCH;
`endif
        end else begin
            case (r_state)
                FETCH: begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if ((r_idx == '0) && w_misaligned) begin
                        r_state <= FAULT;
                        r_fault <= 1'b1;
                    end else
`endif
                    begin
                        r_asm <= w_asmNext;
                        if (r_idx == LAST_IDX) begin
                            r_idx        <= '0;
                            r_state      <= HOLD;
                            r_insValid   <= 1'b1;
                            r_ins        <= w_asmNext;
                            r_insPc      <= r_pc;
                            r_singleNote <= (w_asmNext[NOTE_LSB +: NOTE_W] == '0);
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (r_insValid && i_ins_ready) begin
                        r_pc       <= r_pc + PC_STEP;
                        r_state    <= FETCH;
                        r_insValid <= 1'b0;
                    end
                end
`ifdef FETCH_ALIGN_CHECK_EN
                FAULT: begin
                    r_insValid <= 1'b0;
                end
`endif
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign o_raddr          = w_raddr;
    assign o_ins_valid      = r_insValid;
    assign o_ins            = r_ins;
    assign o_ins_pc         = r_insPc;
    assign o_is_single_note = r_singleNote;
`ifdef FETCH_ALIGN_CHECK_EN
    assign o_fault          = r_fault;
`else
    assign o_fault          = 1'b0;
`endif

endmodule

// File: tb/tb_ins_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ins_fetch_unit
//
// Bench for ins_fetch_unit with default parameters plus a BIG_ENDIAN=1 copy
// driven by the same stimulus. A transaction-level model tracks the PC, the
// fetch progress and the instruction that must be presented, and a compare
// process checks both DUTs against it every cycle. Directed scenarios add
// hand-computed literal expectations on top.
// ----------------------------------------------------------------------------
module tb_ins_fetch_unit;

    localparam int IB = 4;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [63:0] redirectPc;
    logic        ready;

    logic [9:0]  raddrLe, raddrBe;
    logic [7:0]  rdataLe, rdataBe;
    logic        validLe, validBe;
    logic [31:0] insLe, insBe;
    logic [63:0] pcLe, pcBe;
    logic        snLe, snBe;
    logic        faultLe, faultBe;

    logic [7:0]  mem [1024];

    int checks = 0;
    int errors = 0;

    assign rdataLe = mem[raddrLe];
    assign rdataBe = mem[raddrBe];

    always #5 clk = ~clk;

    ins_fetch_unit uDutLe (
        .i_clkOut         (clk),
        .i_reset          (reset),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirectPc),
        .o_raddr          (raddrLe),
        .i_rdata          (rdataLe),
        .o_ins_valid      (validLe),
        .i_ins_ready      (ready),
        .o_ins            (insLe),
        .o_ins_pc         (pcLe),
        .o_is_single_note (snLe),
        .o_fault          (faultLe)
    );

    ins_fetch_unit #(.BIG_ENDIAN(1)) uDutBe (
        .i_clkOut         (clk),
        .i_reset          (reset),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirectPc),
        .o_raddr          (raddrBe),
        .i_rdata          (rdataBe),
        .o_ins_valid      (validBe),
        .i_ins_ready      (ready),
        .o_ins            (insBe),
        .o_ins_pc         (pcBe),
        .o_is_single_note (snBe),
        .o_fault          (faultBe)
    );

    // Instruction word at a PC, read straight from memory in either order.
    function automatic logic [31:0] wordAt(input logic [63:0] pc, input bit be);
        logic [31:0] w;
        logic [63:0] a;
        w = '0;
        for (int k = 0; k < IB; k++) begin
            a = (pc + 64'(k)) & 64'h3FF;
            if (be) w[8*(IB-1-k) +: 8] = mem[a[9:0]];
            else    w[8*k +: 8]        = mem[a[9:0]];
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit rdr, input logic [63:0] rpc, input bit rdy);
        reset      = rst;
        redirect   = rdr;
        redirectPc = rpc;
        ready      = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input bit rdy);
        applyStimulus(1'b1, 1'b0, 64'h0, rdy);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, rdy);
    endtask

    task automatic waitValid(output int n, input int limit);
        bit found;
        n = 0;
        found = 1'b0;
        while (n < limit && !found) begin
            @(negedge clk);
            n++;
            if (validLe) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_valid_timeout actual=0 required=1 after %0d cycles", limit);
        end
    endtask

    // Transaction-level model: a PC, a count of bytes fetched so far, and
    // the instruction that is being offered once the count reaches IB.
    logic [63:0] mPc, mInsPc;
    logic [31:0] mIns, mInsBe;
    int          mCnt;
    bit          mValid, mFault, mSn, mInit;

    initial begin
        mInit = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                mPc = 64'h0; mCnt = 0; mValid = 1'b0; mFault = 1'b0;
                mIns = '0; mInsBe = '0; mInsPc = '0; mSn = 1'b0; mInit = 1'b1;
            end else if (redirect) begin
                mPc = redirectPc; mCnt = 0; mValid = 1'b0;
                mFault = ALIGN && ((redirectPc % IB) != 0);
            end else if (mFault) begin
                mValid = 1'b0;
            end else if (mValid) begin
                if (ready) begin
                    mPc = mPc + IB; mValid = 1'b0; mCnt = 0;
                end
            end else if (ALIGN && mCnt == 0 && (mPc % IB) != 0) begin
                mFault = 1'b1;
            end else begin
                mCnt++;
                if (mCnt == IB) begin
                    mCnt   = 0;
                    mValid = 1'b1;
                    mIns   = wordAt(mPc, 1'b0);
                    mInsBe = wordAt(mPc, 1'b1);
                    mInsPc = mPc;
                    mSn    = (mIns[30:23] == 8'h00);
                end
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    initial begin
        logic [63:0] expAddr;
        forever begin
            @(negedge clk);
            if (mInit) begin
                expAddr = (!mValid && !mFault) ? ((mPc + 64'(mCnt)) & 64'h3FF) : (mPc & 64'h3FF);
                checkOutput("le_valid", 64'(validLe), 64'(mValid));
                checkOutput("le_fault", 64'(faultLe), 64'(mFault));
                checkOutput("le_raddr", 64'(raddrLe), expAddr);
                checkOutput("be_valid", 64'(validBe), 64'(mValid));
                checkOutput("be_raddr", 64'(raddrBe), expAddr);
                if (mValid) begin
                    checkOutput("le_ins", 64'(insLe), 64'(mIns));
                    checkOutput("le_ins_pc", pcLe, mInsPc);
                    checkOutput("le_single_note", 64'(snLe), 64'(mSn));
                    checkOutput("be_ins", 64'(insBe), 64'(mInsBe));
                    checkOutput("be_ins_pc", pcBe, mInsPc);
                end
            end
        end
    end

    // Directed scenarios with literal expectations.
    initial begin
        int n;
        int expA [10] = '{0, 1, 2, 3, 0, 4, 5, 6, 7, 4};
        int expV [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int wrapA [4] = '{32'h3FE, 32'h3FF, 0, 1};

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i + 1);

        // Reset state and sequential fetch with ready held high.
        doReset(1'b1);
        @(negedge clk);
        checkOutput("rst_valid", 64'(validLe), 64'h0);
        checkOutput("rst_ins", 64'(insLe), 64'h0);
        checkOutput("rst_ins_pc", pcLe, 64'h0);
        checkOutput("rst_single_note", 64'(snLe), 64'h0);
        checkOutput("rst_fault", 64'(faultLe), 64'h0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("seq_raddr", 64'(raddrLe), 64'(expA[i]));
            checkOutput("seq_valid", 64'(validLe), 64'(expV[i]));
            if (i == 4) begin
                checkOutput("seq_ins0", 64'(insLe), 64'h04030201);
                checkOutput("seq_pc0", pcLe, 64'h0);
                checkOutput("seq_sn0", 64'(snLe), 64'h0);
                checkOutput("be_ins0", 64'(insBe), 64'h01020304);
            end
            if (i == 9) begin
                checkOutput("seq_ins1", 64'(insLe), 64'h08070605);
                checkOutput("seq_pc1", pcLe, 64'h4);
            end
        end

        // Backpressure: instruction held stable, pc parked at 0.
        doReset(1'b0);
        waitValid(n, 20);
        checkOutput("bp_latency", 64'(n), 64'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", 64'(validLe), 64'h1);
            checkOutput("bp_ins", 64'(insLe), 64'h04030201);
            checkOutput("bp_ins_pc", pcLe, 64'h0);
            checkOutput("bp_raddr", 64'(raddrLe), 64'h0);
        end
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        tick();
        waitValid(n, 20);
        checkOutput("bp_next_pc", pcLe, 64'h4);
        checkOutput("bp_next_ins", 64'(insLe), 64'h08070605);

        // Address wrap and single-note decode.
        mem[10'h3FE] = 8'h00; mem[10'h3FF] = 8'h00; mem[0] = 8'h00; mem[1] = 8'h80;
        doReset(1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 64'h3FE, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("wrap_raddr", 64'(raddrLe), 64'(wrapA[k]));
        end
        @(negedge clk);
        checkOutput("wrap_valid", 64'(validLe), 64'h1);
        checkOutput("wrap_ins", 64'(insLe), 64'h80000000);
        checkOutput("wrap_single_note", 64'(snLe), 64'h1);
        checkOutput("wrap_ins_pc", pcLe, 64'h3FE);
        checkOutput("wrap_be_ins", 64'(insBe), 64'h00000080);
        mem[10'h3FE] = 8'hFF; mem[10'h3FF] = 8'h00; mem[0] = 8'h01; mem[1] = 8'h02;

        // Redirect while idx=2: aborted word never offered.
        doReset(1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 64'h10, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        waitValid(n, 20);
        checkOutput("mid_latency", 64'(n), 64'd5);
        checkOutput("mid_ins_pc", pcLe, 64'h10);
        checkOutput("mid_ins", 64'(insLe), 64'h14131211);

        // Redirect coinciding with an accepted instruction.
        applyStimulus(1'b0, 1'b1, 64'h20, 1'b1);
        tick();
        checkOutput("coin_valid_drop", 64'(validLe), 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        waitValid(n, 20);
        checkOutput("coin_latency", 64'(n), 64'd5);
        checkOutput("coin_ins_pc", pcLe, 64'h20);
        checkOutput("coin_ins", 64'(insLe), 64'h24232221);

        // Misaligned redirect target.
        doReset(1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 64'h6, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("align_fault", 64'(faultLe), 64'h1);
        checkOutput("align_valid", 64'(validLe), 64'h0);
        checkOutput("align_raddr", 64'(raddrLe), 64'h6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("align_fault_sticky", 64'(faultLe), 64'h1);
            checkOutput("align_valid_low", 64'(validLe), 64'h0);
        end
        applyStimulus(1'b0, 1'b1, 64'h8, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        @(negedge clk);
        checkOutput("align_fault_clear", 64'(faultLe), 64'h0);
        waitValid(n, 20);
        checkOutput("align_ins_pc", pcLe, 64'h8);
        checkOutput("align_ins", 64'(insLe), 64'h0C0B0A09);
`else
        checkOutput("mis_raddr", 64'(raddrLe), 64'h6);
        checkOutput("mis_fault", 64'(faultLe), 64'h0);
        waitValid(n, 20);
        checkOutput("mis_ins_pc", pcLe, 64'h6);
        checkOutput("mis_ins", 64'(insLe), 64'h0A090807);
        checkOutput("mis_fault_end", 64'(faultLe), 64'h0);
`endif

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ins_fetch_unit.md
Name: ins_fetch_unit

Overview:
Parametrised instruction fetch unit for the bythoven core. It assembles INS_BYTES-wide instructions from the byte-wide, combinational-read memory port (raddr/rdata), one byte per cycle. It then presents each instruction with its PC and a pre-decoded single-note flag over a valid/ready handshake to the decode stage. It owns the PC: sequential advance, plus redirect for jumps.

Parameters:
PC_W, 64, program counter width
ADDR_W, 10, memory byte-address width (1024 bytes)
INS_BYTES, 4, bytes per instruction; power of two, 1..8
BIG_ENDIAN, 0, 0 = byte k of instruction lands in bits [8k+7:8k]; 1 = byte 0 lands in the top byte
RESET_PC, 0, PC loaded on reset
NOTE_LSB, 23, LSB of the note field used for the single-note decode
NOTE_W, 8, width of the note field; NOTE_LSB+NOTE_W <= 8*INS_BYTES

Ports:
clkOut  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high reset
redirect  in  1  load redirect_pc and restart the fetch
redirect_pc  in  PC_W  target PC
raddr  out  ADDR_W  memory byte address
rdata  in  8  memory byte, combinational from raddr, same cycle
ins_valid  out  1  ins, ins_pc and is_single_note are valid
ins_ready  in  1  consumer accepts the instruction
ins  out  8*INS_BYTES  assembled instruction
ins_pc  out  PC_W  PC of ins
is_single_note  out  1  ins[NOTE_LSB+:NOTE_W] == 0
fault  out  1  misaligned-PC fault (see Optional Feature)

Behaviour:
- Handshake: all outputs are registered except raddr, which is combinational from pc and idx.
- Reset (synchronous, clkOut edge with reset=1):
  - pc=RESET_PC, idx=0, state=FETCH.
  - ins_valid=0, ins=0, ins_pc=0, is_single_note=0, fault=0.
  - Reset overrides redirect and any transfer in progress.
- States: FETCH, HOLD (plus FAULT when FETCH_ALIGN_CHECK_EN).
- FETCH:
  - raddr = (pc[ADDR_W-1:0] + idx) mod 2^ADDR_W; address wraps from 1023 to 0.
  - Each cycle, rdata is captured into lane idx (or lane INS_BYTES-1-idx when BIG_ENDIAN) and idx increments.
  - On the cycle capturing lane INS_BYTES-1: go to HOLD, idx=0, ins_pc=pc, ins_valid=1 next cycle.
  - is_single_note is computed from the fully assembled word and registers with ins_valid.
- HOLD:
  - raddr = pc[ADDR_W-1:0]; memory is not sampled.
  - ins, ins_pc and is_single_note stay stable while ins_valid=1 and ins_ready=0.
  - On ins_valid&&ins_ready: pc = pc+INS_BYTES (mod 2^PC_W), state=FETCH, ins_valid=0 next cycle.
- Latency: ins_valid rises INS_BYTES cycles after FETCH entry. Peak throughput is one instruction per INS_BYTES+1 cycles.
- ins_ready while ins_valid=0 is ignored.
- Redirect (any state, highest priority after reset):
  - pc=redirect_pc, idx=0, state=FETCH, ins_valid=0 next cycle, fault cleared.
  - Partially assembled bytes are discarded.
  - If redirect and ins_valid&&ins_ready coincide: the transfer completes (consumer keeps the instruction) and the next PC is redirect_pc, not pc+INS_BYTES.
- Back-to-back redirects: each one restarts the fetch; only the last target is fetched.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined: on FETCH entry, if pc mod INS_BYTES != 0, go to FAULT instead of reading memory.
  - fault=1 (sticky) and ins_valid=0.
  - FAULT is exited only by redirect or reset.
  - raddr = pc[ADDR_W-1:0] in FAULT.
- Undefined: fault tied to 0, no FAULT state; misaligned PCs fetch bytes pc..pc+INS_BYTES-1 normally.

Test Plan:
- Reset + sequential fetch:
  - Stimulus: mem[0..7]=01 02 03 04 05 06 07 08, ins_ready=1.
  - Response: ins=32'h04030201 at pc 0, then 32'h08070605 at pc 4; ins_valid high every 5th cycle; raddr steps 0,1,2,3,(0),4,5,6,7.
- Backpressure:
  - Stimulus: hold ins_ready=0 for 10 cycles after ins_valid.
  - Response: ins, ins_pc and ins_valid stable; pc stays 0 until ready, then ins_pc=4 on the next instruction.
- BIG_ENDIAN=1:
  - Stimulus: same memory as the first scenario.
  - Response: ins=32'h01020304.
- Single-note decode and address wrap:
  - Stimulus: mem[0x3FE..0x3FF]=00 00 and mem[0..1]=00 80 (word 32'h80000000); redirect_pc=0x3FE.
  - Response: raddr sequence 3FE,3FF,000,001; ins=32'h80000000; is_single_note=1.
- Redirect mid-fetch and coincident with handshake:
  - Stimulus: redirect_pc=0x10 asserted at idx=2.
  - Response: no ins_valid for the aborted word; next ins_pc=0x10.
  - Stimulus: redirect asserted in the same cycle as ins_ready.
  - Response: the instruction is transferred once; next ins_pc=redirect_pc.
- FETCH_ALIGN_CHECK_EN defined:
  - Stimulus: redirect_pc=0x6.
  - Response: fault=1 next cycle, ins_valid stays 0.
  - Stimulus: then redirect_pc=0x8.
  - Response: fault=0, normal fetch at 0x8.
  - Stimulus: same test with the macro undefined.
  - Response: ins built from bytes 6..9, fault=0.
